// File: rtl/ram_b_framer_pkg.sv
// rtl/ram_b_framer_pkg.sv - shared constants and helpers for the RAM B result framer
//
// Holds the framer FSM state encodings, the default frame geometry and
// header byte, and the running-checksum helper used by ram_b_framer.
package ram_b_framer_pkg;

  // Default frame geometry and header byte.
  localparam int unsigned BLOCK_LEN_DEFAULT = 16;
  localparam int unsigned DEPTH_DEFAULT     = 16;
  localparam logic [7:0]  HDR_DEFAULT       = 8'hA5;

  // Output FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_CKS  = 2'd3;

  // Running checksum step: the sum wraps modulo 256.
  function automatic logic [7:0] cks_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/sync_fifo8.sv
// rtl/sync_fifo8.sv - single-clock byte FIFO feeding the RAM B framer
//
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   push, din    - write request and byte; ignored while full
//   pop, dout    - read request and head byte; ignored while empty
//   full, empty  - derived from the registered occupancy count
//   count        - registered occupancy, 0..DEPTH
module sync_fifo8
  import ram_b_framer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Explicit wrap keeps the pointers inside the array for any DEPTH.
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop cancel out.
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: zeroing the pointers and count discards it.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ram_b_framer.sv
// rtl/ram_b_framer.sv - frames RAM B result bytes as header, payload, checksum
//
// Ports:
//   CLK, RESET           - clock and synchronous active-high reset
//   DIN, DIN_VALID       - upstream result bytes; dropped while the FIFO is full
//   IN_READY             - FIFO not full (registered count)
//   OUT_DATA, OUT_VALID  - framed byte stream: HDR, BLOCK_LEN payload bytes, checksum
//   OUT_READY            - downstream accept; handshake = OUT_VALID & OUT_READY
//   OUT_LAST             - marks the checksum byte
//   OVERFLOW             - sticky flag, a byte was dropped
//   FRAME_CNT            - completed frames, wraps at 256
module ram_b_framer
  import ram_b_framer_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned BLOCK_LEN = BLOCK_LEN_DEFAULT,
  parameter logic [7:0]  HDR       = HDR_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       IN_READY,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       OUT_LAST,
  output logic       OVERFLOW,
  output logic [7:0] FRAME_CNT
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(BLOCK_LEN + 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    cks_q, cks_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          overflow_q, overflow_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
  logic          fifo_pop;

  sync_fifo8 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .reset (RESET),
    .push  (DIN_VALID),
    .din   (DIN),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign IN_READY  = ~fifo_full;
  assign OUT_VALID = (state_q != ST_IDLE);
  assign OUT_LAST  = (state_q == ST_CKS);
  assign OVERFLOW  = overflow_q;
  assign FRAME_CNT = frame_cnt_q;

  // A frame only starts with a full block buffered, so the empty guard
  // never actually blocks a payload pop.
  assign fifo_pop = (state_q == ST_PAY) & OUT_READY & ~fifo_empty;

  // Output byte depends only on state and registered data, so it holds
  // steady through any stall.
  always_comb begin
    OUT_DATA = 8'h00;
    case (state_q)
      ST_HDR:  OUT_DATA = HDR;
      ST_PAY:  OUT_DATA = fifo_dout;
      ST_CKS:  OUT_DATA = cks_q;
      default: OUT_DATA = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cks_d       = cks_q;
    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q | (DIN_VALID & fifo_full);

    case (state_q)
      ST_IDLE: begin
        if (fifo_count >= CW'(BLOCK_LEN)) begin
          state_d = ST_HDR;
          cks_d   = 8'h00;
          beat_d  = '0;
        end
      end
      ST_HDR: begin
        if (OUT_READY) begin
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (OUT_READY) begin
          cks_d  = cks_add(cks_q, fifo_dout);
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(BLOCK_LEN - 1)) begin
            state_d = ST_CKS;
          end
        end
      end
      ST_CKS: begin
        if (OUT_READY) begin
          state_d     = ST_IDLE;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cks_q       <= 8'h00;
      beat_q      <= '0;
      frame_cnt_q <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cks_q       <= cks_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_ram_b_framer.sv
// tb/tb_ram_b_framer.sv - self-checking bench for ram_b_framer
module tb_ram_b_framer;

  localparam int         BL    = 16;
  localparam int         DEPTH = 16;
  localparam logic [7:0] HDR   = 8'hA5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] DIN = 8'h00;
  logic       DIN_VALID = 1'b0;
  logic       OUT_READY = 1'b0;
  logic       IN_READY;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_LAST;
  logic       OVERFLOW;
  logic [7:0] FRAME_CNT;

  ram_b_framer #(
    .DEPTH     (DEPTH),
    .BLOCK_LEN (BL),
    .HDR       (HDR)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .IN_READY  (IN_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_LAST  (OUT_LAST),
    .OVERFLOW  (OVERFLOW),
    .FRAME_CNT (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;

  // Reference model state: bytes accepted, bytes seen at the output,
  // occupancy, sticky overflow, frame counter, position within frame.
  logic [7:0] acc_q[$];
  logic [8:0] got_q[$];
  int         model_cnt = 0;
  logic       exp_ovf = 1'b0;
  logic [7:0] exp_fc = 8'h00;
  int         pos = 0;
  logic       stall = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       stall_last = 1'b0;
  int         m_push;
  int         m_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      passed++;
    end
  endtask

  // Inputs change only at posedge+1, so at the negedge every value here
  // describes what the coming rising edge will do.
  always @(negedge CLK) begin
    if (RESET) begin
      model_cnt = 0;
      exp_ovf   = 1'b0;
      exp_fc    = 8'h00;
      pos       = 0;
      stall     = 1'b0;
      acc_q.delete();
      got_q.delete();
    end else begin
      chk("in_ready", IN_READY, model_cnt != DEPTH);
      chk("overflow", OVERFLOW, exp_ovf);
      chk("frame_cnt", FRAME_CNT, exp_fc);
      if (stall) begin
        chk("stall_data", OUT_DATA, stall_data);
        chk("stall_last", OUT_LAST, stall_last);
      end
      stall      = OUT_VALID && !OUT_READY;
      stall_data = OUT_DATA;
      stall_last = OUT_LAST;
      m_push = 0;
      m_pop  = 0;
      if (OUT_VALID && OUT_READY) begin
        got_q.push_back({OUT_LAST, OUT_DATA});
        if (pos >= 1 && pos <= BL) m_pop = 1;
        if (pos == BL + 1) begin
          pos = 0;
          exp_fc = exp_fc + 8'd1;
        end else begin
          pos++;
        end
      end
      if (DIN_VALID) begin
        if (model_cnt != DEPTH) begin
          acc_q.push_back(DIN);
          m_push = 1;
        end else begin
          exp_ovf = 1'b1;
        end
      end
      model_cnt = model_cnt + m_push - m_pop;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    DIN       = b;
    DIN_VALID = 1'b1;
    step();
    DIN_VALID = 1'b0;
  endtask

  task automatic reset_dut();
    RESET     = 1'b1;
    DIN_VALID = 1'b0;
    OUT_READY = 1'b0;
    step();
    step();
    RESET = 1'b0;
    chk("rst_valid", OUT_VALID, 1'b0);
    chk("rst_last", OUT_LAST, 1'b0);
    chk("rst_data", OUT_DATA, 8'h00);
    chk("rst_in_ready", IN_READY, 1'b1);
    chk("rst_overflow", OVERFLOW, 1'b0);
    chk("rst_frame_cnt", FRAME_CNT, 8'h00);
  endtask

  task automatic drain();
    DIN_VALID = 1'b0;
    OUT_READY = 1'b1;
    repeat (3 * (BL + 2) + 6) step();
  endtask

  // Expected stream: every complete block of accepted bytes becomes
  // header, payload, then the modulo-256 sum flagged as last.
  task automatic check_stream(input string tag);
    logic [8:0] e[$];
    logic [7:0] s;
    int nf;
    nf = acc_q.size() / BL;
    for (int f = 0; f < nf; f++) begin
      e.push_back({1'b0, HDR});
      s = 8'h00;
      for (int i = 0; i < BL; i++) begin
        s = s + acc_q[f * BL + i];
        e.push_back({1'b0, acc_q[f * BL + i]});
      end
      e.push_back({1'b1, s});
    end
    chk({tag, "_len"}, got_q.size(), e.size());
    for (int k = 0; k < e.size() && k < got_q.size(); k++) begin
      chk({tag, "_byte"}, got_q[k], e[k]);
      if (got_q[k] !== e[k]) break;
    end
  endtask

  initial begin
    int n;

    // Basic frame with latency and contiguity checks.
    reset_dut();
    OUT_READY = 1'b1;
    for (int i = 1; i <= BL; i++) push_byte(8'(i));
    chk("lat_idle", OUT_VALID, 1'b0);
    step();
    chk("lat_hdr_valid", OUT_VALID, 1'b1);
    chk("lat_hdr_data", OUT_DATA, HDR);
    for (int i = 1; i <= BL + 1; i++) begin
      step();
      chk("frm_valid", OUT_VALID, 1'b1);
      chk("frm_last", OUT_LAST, i == BL + 1);
    end
    chk("basic_cks", OUT_DATA, 8'h88);
    step();
    chk("gap_idle", OUT_VALID, 1'b0);
    chk("basic_frame_cnt", FRAME_CNT, 8'd1);
    check_stream("basic");

    // Checksum wrap.
    reset_dut();
    OUT_READY = 1'b1;
    for (int i = 0; i < BL; i++) push_byte(8'hFF);
    repeat (BL + 2) step();
    chk("ff_last", OUT_LAST, 1'b1);
    chk("ff_cks", OUT_DATA, 8'hF0);
    drain();
    check_stream("ff");

    // Backpressure toggling every cycle.
    reset_dut();
    OUT_READY = 1'b1;
    for (int i = 1; i <= BL; i++) push_byte(8'(i));
    repeat (60) begin
      OUT_READY = ~OUT_READY;
      step();
    end
    drain();
    chk("bp_frame_cnt", FRAME_CNT, 8'd1);
    check_stream("bp");

    // Overflow while output is stalled.
    reset_dut();
    OUT_READY = 1'b0;
    for (int i = 0; i < BL; i++) push_byte(8'(8'h40 + i));
    chk("ovf_in_ready", IN_READY, 1'b0);
    chk("ovf_not_yet", OVERFLOW, 1'b0);
    push_byte(8'h99);
    chk("ovf_set", OVERFLOW, 1'b1);
    chk("ovf_hdr_wait", OUT_DATA, HDR);
    drain();
    chk("ovf_sticky", OVERFLOW, 1'b1);
    check_stream("ovf");

    // Reset after the fifth payload handshake.
    reset_dut();
    OUT_READY = 1'b1;
    for (int i = 0; i < BL; i++) push_byte(8'(8'h20 + i));
    step();
    chk("mid_hdr", OUT_DATA, HDR);
    repeat (6) step();
    chk("mid_pay6", OUT_DATA, 8'h25);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("mid_rst_valid", OUT_VALID, 1'b0);
    chk("mid_rst_fc", FRAME_CNT, 8'h00);
    chk("mid_rst_in_ready", IN_READY, 1'b1);
    for (int i = 0; i < BL; i++) push_byte(8'(8'hC0 + 3 * i));
    drain();
    chk("mid_frame_cnt", FRAME_CNT, 8'd1);
    check_stream("mid");

    // Randomized traffic, light then heavy backpressure.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      DIN       = 8'($urandom);
      DIN_VALID = ($urandom_range(0, 3) != 0);
      OUT_READY = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step();
    end
    drain();
    check_stream("rand");

    // 256 frames wrap the frame counter.
    reset_dut();
    OUT_READY = 1'b1;
    n = 0;
    for (int c = 0; c < 6000 && n < 256 * BL; c++) begin
      DIN       = 8'($urandom);
      DIN_VALID = (model_cnt != DEPTH);
      step();
      if (DIN_VALID) n++;
    end
    DIN_VALID = 1'b0;
    chk("wrap_pushed", n, 256 * BL);
    drain();
    chk("wrap_frame_cnt", FRAME_CNT, 8'h00);
    check_stream("wrap");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
